// File: rtl/shift_ex_if.sv
// rtl/shift_ex_if.sv - upstream/downstream handshake bundle for the shift EX stage
interface shift_ex_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic            in_var;
  logic [4:0]      in_shamt;
  logic [31:0]     in_rs;
  logic [31:0]     in_rt;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [RD_W-1:0] out_rd;

  modport master (
    output in_valid, in_op, in_var, in_shamt, in_rs, in_rt, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  in_valid, in_op, in_var, in_shamt, in_rs, in_rt, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/shift_ex_stage.sv
// rtl/shift_ex_stage.sv - two-slot elastic shift stage (operand latch + result register)
module shift_ex_stage #(
  parameter int RD_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  shift_ex_if.slave   bus,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  logic            s1_valid;
  shift_op_e       s1_op;
  logic [4:0]      s1_amt;
  logic [31:0]     s1_data;
  logic [RD_W-1:0] s1_rd;

  logic            s2_valid;
  logic [31:0]     s2_result;
  logic [RD_W-1:0] s2_rd;

  logic            s2_free;
  logic            accept;
  logic            advance;
  logic            handshake;
  logic [4:0]      amount;
  logic [31:0]     shifted;
  logic            unused_rs_bits;

  function automatic logic [31:0] reverse32(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = d[31-b];
    return r;
  endfunction

  // Single right-shifting barrel; left shifts run through it bit-reversed.
  function automatic logic [31:0] shift_value(input shift_op_e op, input logic [4:0] amt,
                                              input logic [31:0] d);
    logic [31:0] v;
    logic        fill;
    fill = (op == OP_SRA) & d[31];
    v = (op == OP_SLL) ? reverse32(d) : d;
    for (int i = 0; i < 5; i++) begin
      if (amt[i]) v = fill ? ~(~v >> (1 << i)) : (v >> (1 << i));
    end
    if (op == OP_SLL) v = reverse32(v);
    if (op == OP_RSV) v = '0;
    return v;
  endfunction

  assign s2_free      = !s2_valid | bus.out_ready;
  assign bus.in_ready = !rst & !flush & (!s1_valid | s2_free);
  assign accept       = bus.in_valid & bus.in_ready;
  assign advance      = s1_valid & s2_free;
  assign handshake    = s2_valid & bus.out_ready & !flush;

  assign amount         = bus.in_var ? bus.in_rs[4:0] : bus.in_shamt;
  assign unused_rs_bits = ^bus.in_rs[31:5];

  always_comb begin
    shifted = shift_value(s1_op, s1_amt, s1_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_SLL;
      s1_amt    <= '0;
      s1_data   <= '0;
      s1_rd     <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_rd     <= '0;
      retired   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid <= 1'b1;
          s1_op    <= shift_op_e'(bus.in_op);
          s1_amt   <= amount;
          s1_data  <= bus.in_rt;
          s1_rd    <= bus.in_rd;
        end else if (advance) begin
          s1_valid <= 1'b0;
        end

        // S2 holds its contents whenever it is stalled so the output stays stable.
        if (advance) begin
          s2_valid  <= 1'b1;
          s2_result <= shifted;
          s2_rd     <= s1_rd;
        end else if (bus.out_ready) begin
          s2_valid <= 1'b0;
        end
      end

      if (handshake) retired <= retired + 16'd1;
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
  assign bus.out_rd     = s2_rd;

endmodule

// File: tb/tb_shift_ex_stage.sv
// tb/tb_shift_ex_stage.sv - vector table, directed corner sequences and randomized queue-model run
module tb_shift_ex_stage;
  localparam int RD_W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] retired;

  shift_ex_if #(.RD_W(RD_W)) bus();

  shift_ex_stage #(.RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic        vsel;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [31:0] expect_val;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
  } item_t;

  item_t       q[$];
  logic [15:0] exp_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference shift as plain arithmetic: multiply / divide by powers of two.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                            input logic [31:0] d);
    longint unsigned x = {32'd0, d};
    longint unsigned p = 64'd1 << amt;
    longint s = longint'($signed(d));
    longint qv;
    case (op)
      2'b00: begin qv = longint'(x * p); return qv[31:0]; end
      2'b01: begin qv = longint'(x / p); return qv[31:0]; end
      2'b11: begin
        if (s >= 0) qv = s / longint'(p);
        else qv = -((-s + longint'(p) - 1) / longint'(p));
        return qv[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic vsel, input logic [4:0] shamt,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_var   = vsel;
    bus.in_shamt = shamt;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bus.out_ready = 1'b1;
    drive_op(v.op, v.vsel, v.shamt, v.rs, v.rt, v.rd);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d early out_valid", idx), bus.out_valid, 0);
    @(negedge clk);
    check($sformatf("vec%0d out_valid", idx), bus.out_valid, 1);
    check($sformatf("vec%0d out_result", idx), bus.out_result, v.expect_val);
    check($sformatf("vec%0d out_rd", idx), bus.out_rd, v.rd);
    tick();
    exp_ret = exp_ret + 16'd1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 1'b0, 5'd31, 32'h0,        32'h00000001, 5'd5,  32'h80000000};
    vecs[1] = '{2'b11, 1'b1, 5'd0,  32'h00000024, 32'hF0000000, 5'd6,  32'hFF000000};
    vecs[2] = '{2'b01, 1'b1, 5'd0,  32'h00000024, 32'hF0000000, 5'd7,  32'h0F000000};
    vecs[3] = '{2'b10, 1'b1, 5'd0,  32'h00000024, 32'hF0000000, 5'd8,  32'h00000000};
    vecs[4] = '{2'b00, 1'b0, 5'd0,  32'h0,        32'h12345678, 5'd9,  32'h12345678};
    vecs[5] = '{2'b11, 1'b0, 5'd31, 32'h0,        32'h80000000, 5'd10, 32'hFFFFFFFF};
    vecs[6] = '{2'b01, 1'b0, 5'd31, 32'h0,        32'h80000000, 5'd11, 32'h00000001};
    vecs[7] = '{2'b11, 1'b1, 5'd7,  32'hFFFFFFE1, 32'h7FFFFFFE, 5'd12, 32'h3FFFFFFF};
    vecs[8] = '{2'b00, 1'b0, 5'd4,  32'h0,        32'h0000ABCD, 5'd13, 32'h000ABCD0};
    vecs[9] = '{2'b11, 1'b0, 5'd0,  32'h0,        32'h80000001, 5'd31, 32'h80000001};

    rst = 1'b1; flush = 1'b0; exp_ret = 16'd0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = 2'b00; bus.in_var = 1'b0; bus.in_shamt = '0;
    bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    tick(); tick();
    @(negedge clk);
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_result", bus.out_result, 0);
    check("reset out_rd", bus.out_rd, 0);
    check("reset retired", retired, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", bus.in_ready, 1);
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    @(negedge clk);
    check("table retired", retired, exp_ret);
    tick();

    // Backpressure: A,B fill both slots, C must wait.
    bus.out_ready = 1'b0;
    drive_op(2'b00, 1'b0, 5'd1, 32'h0, 32'h00000011, 5'd1); tick();
    drive_op(2'b00, 1'b0, 5'd2, 32'h0, 32'h00000022, 5'd2); tick();
    drive_op(2'b00, 1'b0, 5'd3, 32'h0, 32'h00000033, 5'd3);
    @(negedge clk);
    check("bp in_ready C", bus.in_ready, 0);
    check("bp out_valid", bus.out_valid, 1);
    check("bp hold A", bus.out_result, 32'h00000022);
    tick();
    @(negedge clk);
    check("bp stable A", bus.out_result, 32'h00000022);
    check("bp stable rd", bus.out_rd, 1);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", bus.in_ready, 1);
    check("bp emit A", bus.out_result, 32'h00000022);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp emit B", bus.out_result, 32'h00000088);
    check("bp B valid", bus.out_valid, 1);
    tick();
    @(negedge clk);
    check("bp emit C", bus.out_result, 32'h00000198);
    check("bp C valid", bus.out_valid, 1);
    tick();
    exp_ret = exp_ret + 16'd3;
    @(negedge clk);
    check("bp drained", bus.out_valid, 0);
    check("bp retired", retired, exp_ret);
    tick();

    // Flush with both slots full; the offered op must not be accepted.
    bus.out_ready = 1'b0;
    drive_op(2'b01, 1'b0, 5'd4, 32'h0, 32'hFFFF0000, 5'd4); tick();
    drive_op(2'b01, 1'b0, 5'd8, 32'h0, 32'hFFFF0000, 5'd5); tick();
    @(negedge clk);
    check("flush pre out_valid", bus.out_valid, 1);
    flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush out_valid", bus.out_valid, 0);
    check("flush retired", retired, exp_ret);
    check("flush in_ready after", bus.in_ready, 1);
    tick(); tick();
    @(negedge clk);
    check("flush no ghost", bus.out_valid, 0);
    tick();

    // Reset with both slots full.
    bus.out_ready = 1'b0;
    drive_op(2'b11, 1'b0, 5'd2, 32'h0, 32'h80000000, 5'd6); tick();
    drive_op(2'b11, 1'b0, 5'd3, 32'h0, 32'h80000000, 5'd7); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_result", bus.out_result, 0);
    check("rst out_rd", bus.out_rd, 0);
    check("rst retired", retired, 0);
    check("rst in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0; bus.out_ready = 1'b1; exp_ret = 16'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst stale c%0d", c), bus.out_valid, 0);
      tick();
    end

    // Counter wrap: stream 0xFFFF ops, then one more.
    drive_op(2'b00, 1'b0, 5'd1, 32'h0, 32'h1, 5'd3);
    for (int c = 0; c < 65535; c++) tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("wrap preload", retired, 16'hFFFF);
    tick();
    exp_ret = 16'hFFFF;
    run_vec(vecs[0], 100);
    @(negedge clk);
    check("wrap to zero", retired, exp_ret);
    tick();

    // Randomized run against the queue model.
    begin
      logic exp_ready;
      logic stall_prev = 1'b0;
      logic [31:0] rs_r, rt_r;
      logic [1:0] op_r;
      logic [4:0] sh_r, rd_r;
      logic v_r;
      q.delete();
      for (int c = 0; c < 3000; c++) begin
        op_r = 2'($urandom); v_r = 1'($urandom); sh_r = 5'($urandom);
        rs_r = $urandom; rt_r = $urandom; rd_r = 5'($urandom);
        drive_op(op_r, v_r, sh_r, rs_r, rt_r, rd_r);
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 40) == 0);
        rst   = ($urandom_range(0, 150) == 0);
        @(negedge clk);
        exp_ready = !rst && !flush && (q.size() < 2 || bus.out_ready);
        check("rnd in_ready", bus.in_ready, exp_ready);
        check("rnd retired", retired, exp_ret);
        if (q.size() == 0) check("rnd empty out_valid", bus.out_valid, 0);
        if (q.size() == 2) check("rnd full out_valid", bus.out_valid, 1);
        if (stall_prev) check("rnd stall out_valid", bus.out_valid, 1);
        if (bus.out_valid && q.size() > 0) begin
          check("rnd out_result", bus.out_result, q[0].result);
          check("rnd out_rd", bus.out_rd, q[0].rd);
        end
        stall_prev = bus.out_valid && !bus.out_ready && !flush && !rst;
        if (rst) begin
          q.delete();
          exp_ret = 16'd0;
        end else if (flush) begin
          q.delete();
        end else begin
          if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            void'(q.pop_front());
            exp_ret = exp_ret + 16'd1;
          end
          if (exp_ready && bus.in_valid)
            q.push_back('{ref_shift(op_r, v_r ? rs_r[4:0] : sh_r, rt_r), rd_r});
        end
        tick();
      end

      // Drain with a bounded budget.
      rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          check("drain out_result", bus.out_result, q[0].result);
          void'(q.pop_front());
          exp_ret = exp_ret + 16'd1;
        end
        tick();
      end
      check("drain queue empty", q.size(), 0);
      @(negedge clk);
      check("drain retired", retired, exp_ret);
      check("drain out_valid", bus.out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_ex_stage.md
SHIFT_EX_STAGE -- requirements
Module: shift_ex_stage

Interface
REQ-001 Parameter: RD_W, 5, destination-register index width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 flush  in  1  discard all in-flight shift operations.
REQ-005 in_valid  in  1  upstream (ID) offers a shift operation.
REQ-006 in_ready  out  1  stage accepts the operation this cycle.
REQ-007 in_op  in  2  00 SLL, 01 SRL, 10 reserved (result 0), 11 SRA.
REQ-008 in_var  in  1  1: amount = in_rs[4:0] (sllv/srlv/srav); 0: amount = in_shamt.
REQ-009 in_shamt  in  5  immediate shift amount.
REQ-010 in_rs  in  32  rs operand, amount source when in_var=1.
REQ-011 in_rt  in  32  data to shift.
REQ-012 in_rd  in  RD_W  destination register tag.
REQ-013 out_valid  out  1  result available to EX/MEM.
REQ-014 out_ready  in  1  downstream consumes the result this cycle.
REQ-015 out_result  out  32  shifted value.
REQ-016 out_rd  out  RD_W  destination tag travelling with out_result.
REQ-017 retired  out  16  count of completed output handshakes.

Function
REQ-018 The stage SHALL be a two-slot elastic pipeline: S1 (operand latch) and S2 (result register), each with a valid bit.
REQ-019 Accept = in_valid & in_ready; on accept, S1 SHALL capture op, resolved 5-bit amount (per REQ-008), in_rt and in_rd.
REQ-020 s2_free = !s2_valid | out_ready; in_ready SHALL equal !rst & !flush & (!s1_valid | s2_free).
REQ-021 When s1_valid & s2_free, S2 SHALL capture the shift of the S1 operands and S1's tag; otherwise S2 holds.
REQ-022 Shift semantics: SLL zero-fill left; SRL zero-fill right; SRA replicates bit 31; op 10 yields 0x00000000; only amount bits [4:0] are used; amount 0 passes data unchanged.
REQ-023 Latency SHALL be 2 cycles from accept edge to out_valid with out_ready held high; throughput 1 operation/cycle.
REQ-024 Output handshake = out_valid & out_ready; out_valid SHALL equal s2_valid.
REQ-025 While out_valid & !out_ready, out_result, out_rd and out_valid SHALL remain stable.
REQ-026 Operations SHALL leave in acceptance order; none duplicated or dropped except by flush/rst.
REQ-027 flush=1 SHALL clear s1_valid and s2_valid at that edge, suppress accept that cycle, and not count a handshake in that cycle.
REQ-028 retired SHALL increment by 1 on each output handshake (not in a flush cycle), wrapping 0xFFFF -> 0x0000.
REQ-029 Simultaneous S1->S2 transfer and new accept SHALL both occur in the same cycle.

Reset
REQ-030 On rst, at the next edge: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_rd=0, retired=0.
REQ-031 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-032 rst mid-operation SHALL discard all in-flight operations; no output handshake follows for them.

Verification
REQ-033 SLL: in_rt=0x00000001, in_shamt=31, in_var=0, in_op=00, out_ready=1 -> 2 cycles later out_result=0x80000000, out_rd matches.
REQ-034 SRAV: in_rs=0x00000024, in_rt=0xF0000000, in_var=1, in_op=11 -> out_result=0xFF000000; same with in_op=01 -> 0x0F000000; in_op=10 -> 0x00000000.
REQ-035 Backpressure: out_ready=0, three back-to-back in_valid ops A,B,C -> A,B accepted, in_ready=0 while C offered, out_result=A stable; raise out_ready -> A,B,C emitted on consecutive cycles, retired +3.
REQ-036 Flush with S1 and S2 full -> out_valid=0 next cycle, retired unchanged, in_ready=1 following cycle.
REQ-037 Preload retired near wrap via 0xFFFF handshakes -> next handshake gives retired=0x0000.
REQ-038 Assert rst with both slots valid -> next cycle all outputs at reset values, no stale result emitted after release.
